// File: rtl/com_pkg.sv
// Shared types and constants for the command scheduler.
package com_pkg;

   localparam int NUM_SIGNALS_DEF = 16;
   localparam int HOLD_CYCLES_DEF = 8;

   // All command lines idle. Command lines are active-low.
   localparam logic [NUM_SIGNALS_DEF-1:0] COM_IDLE = {NUM_SIGNALS_DEF{1'b1}};

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      HOLD
   } sched_state_t;

endpackage

// File: rtl/com_scheduler_if.sv
// Valid/ready command handshake from the scheduler to the downstream transmitter.
interface com_scheduler_if #(
   parameter int IDX_WIDTH = 4
) ();

   logic                 tx_valid;
   logic                 tx_ready;
   logic [IDX_WIDTH-1:0] tx_index;

   modport master (
      output tx_valid,
      output tx_index,
      input  tx_ready
   );

   modport slave (
      input  tx_valid,
      input  tx_index,
      output tx_ready
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting line at or after ptr,
// wrapping modulo NUM_SIGNALS.
module rr_arbiter #(
   parameter int NUM_SIGNALS = 16,
   parameter int IDX_WIDTH   = $clog2(NUM_SIGNALS)
) (
   input  logic [NUM_SIGNALS-1:0] req,
   input  logic [IDX_WIDTH-1:0]   ptr,
   output logic [IDX_WIDTH-1:0]   gnt_idx,
   output logic                   gnt_any
);

   // Scan the request vector starting at ptr; the first hit wins.
   always_comb begin
      logic [IDX_WIDTH-1:0] cand;
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      for (int i = 0; i < NUM_SIGNALS; i++) begin
         cand = IDX_WIDTH'((int'(ptr) + i) % NUM_SIGNALS);
         if (!gnt_any && req[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

endmodule

// File: rtl/com_scheduler.sv
// Command sequencer: edge-detects active-low command lines, latches them as
// pending, and issues them one at a time round-robin with a minimum gap.
module com_scheduler
   import com_pkg::*;
#(
   parameter int NUM_SIGNALS = NUM_SIGNALS_DEF,
   parameter int IDX_WIDTH   = $clog2(NUM_SIGNALS),
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
   input  logic                   clk,
   input  logic                   aclr_n,
   input  logic [NUM_SIGNALS-1:0] com_n,
   input  logic [NUM_SIGNALS-1:0] mask,
   input  logic                   ovf_clr,
   com_scheduler_if.master        tx,
   output logic [NUM_SIGNALS-1:0] pending,
   output logic [NUM_SIGNALS-1:0] ovf_flags,
   output logic                   busy
);

   // Counter is at least one bit wide even when HOLD_CYCLES is 1.
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   sched_state_t             state;
   sched_state_t             state_next;
   logic [NUM_SIGNALS-1:0]   com_prev;
   logic [NUM_SIGNALS-1:0]   rise;
   logic [NUM_SIGNALS-1:0]   accept_vec;
   logic                     accept;
   logic [IDX_WIDTH-1:0]     tx_index_q;
   logic [IDX_WIDTH-1:0]     rr_ptr;
   logic [IDX_WIDTH-1:0]     gnt_idx;
   logic                     gnt_any;
   logic [HOLD_W-1:0]        hold_cnt;

   rr_arbiter #(
      .NUM_SIGNALS (NUM_SIGNALS),
      .IDX_WIDTH   (IDX_WIDTH)
   ) u_arb (
      .req     (pending),
      .ptr     (rr_ptr),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // A rise is a 1->0 transition on an enabled line; held-low lines never re-trigger.
   assign rise   = com_prev & ~com_n & mask;
   assign accept = (state == ISSUE) && tx.tx_ready;

   // One-hot of the command being accepted this cycle.
   always_comb begin
      accept_vec = '0;
      if (accept) accept_vec[tx_index_q] = 1'b1;
   end

   // Previous command-line sample for edge detection.
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         com_prev <= '1;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
         com_prev <= com_n;
      end
   end

   // Pending and sticky overflow bits; a same-cycle rise beats both accept-clear and ovf_clr.
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         pending   <= '0;
         ovf_flags <= '0;
      end else begin
         pending   <= (pending & ~accept_vec) | rise;
         ovf_flags <= (ovf_flags & ~{NUM_SIGNALS{ovf_clr}}) | (rise & pending & ~accept_vec);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) state <= IDLE;
      else         state <= state_next;
   end

   // FSM next-state logic.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (gnt_any)           state_next = ISSUE;
         ISSUE:   if (tx.tx_ready)       state_next = HOLD;
         HOLD:    if (hold_cnt == '0)    state_next = IDLE;
         default:                        state_next = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      tx.tx_valid = (state == ISSUE);
      busy        = (state != IDLE);
   end

   assign tx.tx_index = tx_index_q;

   // Grant latch, round-robin pointer and post-accept gap counter.
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         tx_index_q <= '0;
         rr_ptr     <= '0;
         hold_cnt   <= '0;
      end else begin
         if (state == IDLE && gnt_any) tx_index_q <= gnt_idx;
         if (accept) begin
            rr_ptr   <= (tx_index_q == IDX_WIDTH'(NUM_SIGNALS - 1)) ? '0 : tx_index_q + 1'b1;
            hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
         end else if (state == HOLD && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_com_scheduler.sv
// Self-checking bench for com_scheduler: directed table, corner-case
// sequences and randomized traffic against a behavioural model.
module tb_com_scheduler;
   import com_pkg::*;

   localparam int N    = 16;
   localparam int HOLD = 8;

   logic          clk = 1'b0;
   logic          aclr_n;
   logic [N-1:0]  com_n;
   logic [N-1:0]  mask;
   logic          ovf_clr;
   logic [N-1:0]  pending;
   logic [N-1:0]  ovf_flags;
   logic          busy;

   com_scheduler_if #(.IDX_WIDTH(4)) txif ();

   com_scheduler #(
      .NUM_SIGNALS (N),
      .IDX_WIDTH   (4),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk       (clk),
      .aclr_n    (aclr_n),
      .com_n     (com_n),
      .mask      (mask),
      .ovf_clr   (ovf_clr),
      .tx        (txif.master),
      .pending   (pending),
      .ovf_flags (ovf_flags),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int issued[$];

   // Behavioural model: lines waiting, lines that overflowed, whether a
   // command is on offer, and how many quiet cycles remain after an accept.
   bit [N-1:0] m_prev, m_pend, m_ovf;
   bit         m_offer;
   int         m_idx, m_gap, m_ptr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_prev  = '1;
      m_pend  = '0;
      m_ovf   = '0;
      m_offer = 1'b0;
      m_idx   = 0;
      m_gap   = 0;
      m_ptr   = 0;
   endfunction

   function automatic void model_edge();
      bit [N-1:0] rise, acc, new_pend, new_ovf;
      bit         accepted;
      rise     = m_prev & ~com_n & mask;
      accepted = m_offer && (txif.tx_ready === 1'b1);
      acc      = '0;
      if (accepted) acc[m_idx] = 1'b1;
      new_pend = (m_pend & ~acc) | rise;
      new_ovf  = (m_ovf & ~{N{ovf_clr}}) | (rise & m_pend & ~acc);
      if (m_offer) begin
         if (accepted) begin
            m_offer = 1'b0;
            m_gap   = HOLD;
            m_ptr   = (m_idx + 1) % N;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (m_pend != '0) begin
         for (int i = 0; i < N; i++) begin
            if (m_pend[(m_ptr + i) % N]) begin
               m_idx   = (m_ptr + i) % N;
               m_offer = 1'b1;
               break;
            end
         end
      end
      m_pend = new_pend;
      m_ovf  = new_ovf;
      m_prev = com_n;
   endfunction

   task automatic compare_model();
      check("model tx_valid", 32'(txif.tx_valid), 32'(m_offer));
      if (m_offer) check("model tx_index", 32'(txif.tx_index), 32'(m_idx));
      check("model pending", 32'(pending), 32'(m_pend));
      check("model ovf_flags", 32'(ovf_flags), 32'(m_ovf));
      check("model busy", 32'(busy), 32'(m_offer || m_gap > 0));
   endtask

   // One clock: record accepted commands, advance the model, sample #1 after the edge.
   task automatic step();
      if (txif.tx_valid === 1'b1 && txif.tx_ready === 1'b1) issued.push_back(int'(txif.tx_index));
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   task automatic do_reset();
      aclr_n        = 1'b0;
      com_n         = COM_IDLE;
      mask          = '1;
      ovf_clr       = 1'b0;
      txif.tx_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      aclr_n = 1'b1;
   endtask

   typedef struct {
      logic [N-1:0] com_n;
      logic         tx_ready;
      logic         exp_valid;
      logic [3:0]   exp_idx;
      logic [N-1:0] exp_pend;
      logic         exp_busy;
   } vec_t;

   vec_t vecs[11];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int budget;

      // ---- directed table: single command on bit 2 ----
      vecs[0] = '{16'hFFFB, 1'b1, 1'b0, 4'd0, 16'h0004, 1'b0};
      vecs[1] = '{16'hFFFB, 1'b1, 1'b1, 4'd2, 16'h0004, 1'b1};
      for (int i = 2; i < 10; i++) vecs[i] = '{16'hFFFF, 1'b1, 1'b0, 4'd2, 16'h0000, 1'b1};
      vecs[10] = '{16'hFFFF, 1'b1, 1'b0, 4'd2, 16'h0000, 1'b0};

      do_reset();
      #1;
      check("reset tx_valid", 32'(txif.tx_valid), 32'd0);
      check("reset tx_index", 32'(txif.tx_index), 32'd0);
      check("reset pending", 32'(pending), 32'd0);
      check("reset ovf_flags", 32'(ovf_flags), 32'd0);
      check("reset busy", 32'(busy), 32'd0);

      for (int i = 0; i < 11; i++) begin
         com_n         = vecs[i].com_n;
         txif.tx_ready = vecs[i].tx_ready;
         step();
         check($sformatf("vec%0d tx_valid", i), 32'(txif.tx_valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d tx_index", i), 32'(txif.tx_index), 32'(vecs[i].exp_idx));
         check($sformatf("vec%0d pending", i), 32'(pending), 32'(vecs[i].exp_pend));
         check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      end

      // ---- round-robin over all 16 lines, including wrap ----
      do_reset();
      txif.tx_ready = 1'b1;
      issued.delete();
      com_n = 16'h0000;
      step();
      com_n = COM_IDLE;
      budget = 0;
      while ((issued.size() < 16 || busy) && budget < 400) begin
         step();
         budget++;
      end
      check("rr finished in budget", 32'(budget < 400), 32'd1);
      check("rr issue count", 32'(issued.size()), 32'd16);
      for (int i = 0; i < 16 && i < issued.size(); i++)
         check($sformatf("rr order %0d", i), 32'(issued[i]), 32'(i));
      check("rr pending", 32'(pending), 32'd0);
      check("rr busy", 32'(busy), 32'd0);

      // ---- backpressure: bit 5 held on offer ----
      do_reset();
      issued.delete();
      com_n = ~(16'h0001 << 5);
      step();
      com_n = COM_IDLE;
      step();
      for (int i = 0; i < 10; i++) begin
         step();
         check($sformatf("bp valid c%0d", i), 32'(txif.tx_valid), 32'd1);
         check($sformatf("bp index c%0d", i), 32'(txif.tx_index), 32'd5);
      end
      txif.tx_ready = 1'b1;
      step();
      check("bp accepted once", 32'(issued.size()), 32'd1);
      check("bp valid after accept", 32'(txif.tx_valid), 32'd0);
      check("bp pending after accept", 32'(pending), 32'd0);

      // ---- overflow on bit 3, set-wins-over-clear, then clear ----
      do_reset();
      com_n = 16'hFFF7; step();
      com_n = COM_IDLE; step();
      com_n = 16'hFFF7; step();
      check("ovf set", 32'(ovf_flags), 32'h0008);
      com_n = COM_IDLE; step();
      com_n = 16'hFFF7; ovf_clr = 1'b1; step();
      check("ovf set beats clr", 32'(ovf_flags), 32'h0008);
      com_n = COM_IDLE; step();
      ovf_clr = 1'b0; step();
      check("ovf cleared", 32'(ovf_flags), 32'h0000);
      check("ovf pending kept", 32'(pending), 32'h0008);

      // ---- masked line, then unmasked while still held low ----
      do_reset();
      mask  = 16'hFFFE;
      com_n = 16'hFFFE;
      repeat (3) step();
      check("masked no pending", 32'(pending), 32'd0);
      mask = '1;
      repeat (3) step();
      check("held low no pending", 32'(pending), 32'd0);
      check("held low not busy", 32'(busy), 32'd0);

      // ---- async reset while a command is offered ----
      do_reset();
      com_n = 16'hFF7F; step();
      com_n = COM_IDLE; step();
      check("pre-reset tx_valid", 32'(txif.tx_valid), 32'd1);
      #2;
      aclr_n = 1'b0;
      model_reset();
      #1;
      check("async reset tx_valid", 32'(txif.tx_valid), 32'd0);
      check("async reset pending", 32'(pending), 32'd0);
      @(negedge clk);
      aclr_n = 1'b1;
      repeat (3) step();
      check("post-reset busy", 32'(busy), 32'd0);

      // ---- randomized traffic against the model ----
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         com_n         = com_n ^ N'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 15) == 0) mask = N'($urandom | $urandom);
         txif.tx_ready = ($urandom_range(0, 3) != 0);
         ovf_clr       = ($urandom_range(0, 31) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
